fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 66 ++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register plus IF/ID pipeline register; perf counters under FETCH_PERF_CNT_EN.
// Latency: adrs is the PC combinationally, and the fetched word lands in IF/ID one cycle later.
// Backpressure: freeze holds PC and IF/ID, and branch_taken overrides freeze by redirecting and flushing.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_adrs,
    input  logic [31:0] inst_in,
    output logic [31:0] adrs,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        valid_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    logic [31:0] pc;
    logic [31:0] pc_inc;

    assign pc_inc = pc + PC_STEP;
    assign adrs   = pc;

    // A redirect wins over freeze; a flushed slot reads as a zero NOP with valid low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc        <= RESET_PC;
            inst_out  <= 32'd0;
            pc_out    <= 32'd0;
            valid_out <= 1'b0;
        end else if (branch_taken) begin
            pc        <= branch_adrs;
            inst_out  <= 32'd0;
            pc_out    <= 32'd0;
            valid_out <= 1'b0;
        end else if (!freeze) begin
            pc        <= pc_inc;
            inst_out  <= inst_in;
            pc_out    <= pc_inc;
            valid_out <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt <= 32'd0;
            stall_cnt <= 32'd0;
        end else if (!branch_taken) begin
            if (freeze) begin
                stall_cnt <= stall_cnt + 32'd1;
            end else begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
